input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive cycles of agreement required before a level is accepted (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port d_async  input  1  raw asynchronous/bouncy input level.
REQ-006 SHALL have port clear_glitch  input  1  synchronous clear of glitch_count.
REQ-007 SHALL have port q_clean  output  1  debounced level; this is the d input of the downstream dffr stage.
REQ-008 SHALL have port rise_pulse  output  1  one-cycle pulse when q_clean goes 0->1.
REQ-009 SHALL have port fall_pulse  output  1  one-cycle pulse when q_clean goes 1->0.
REQ-010 SHALL have port stable  output  1  high when the FSM is in STABLE_LO or STABLE_HI.
REQ-011 SHALL have port glitch_count  output  8  saturating count of rejected transitions.

Function
REQ-012 SHALL pass d_async through a SYNC_STAGES-deep flop chain; d_sync is the last stage; no other logic reads d_async.
REQ-013 SHALL implement FSM states STABLE_LO, CONFIRM_HI, STABLE_HI, CONFIRM_LO, with a counter cnt of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-014 STABLE_LO: d_sync=1 -> CONFIRM_HI with cnt=1; else stay.
REQ-015 CONFIRM_HI: d_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HI, q_clean<=1, rise_pulse<=1; d_sync=1 otherwise -> cnt+1; d_sync=0 -> STABLE_LO, glitch_count+1.
REQ-016 STABLE_HI / CONFIRM_LO SHALL mirror REQ-014/015 with polarity inverted (fall_pulse, q_clean<=0).
REQ-017 q_clean, rise_pulse, fall_pulse, stable SHALL be registered outputs with no combinational path from any input.
REQ-018 rise_pulse and fall_pulse SHALL be exactly one cycle wide and never both high.
REQ-019 Latency: for d_async settled before capture edge 1, q_clean SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults), not earlier.
REQ-020 A d_sync pulse shorter than DEBOUNCE_CYCLES cycles SHALL leave q_clean unchanged and increment glitch_count once.
REQ-021 glitch_count SHALL saturate at 255 and not wrap.
REQ-022 clear_glitch=1 SHALL set glitch_count to 0 next edge; if a glitch occurs the same cycle, clear wins (result 0).
REQ-023 stable SHALL be 0 in CONFIRM_HI/CONFIRM_LO, 1 otherwise.

Reset
REQ-024 reset_n=0 SHALL immediately (without clk) force synchronizer flops 0, state STABLE_LO, cnt 0, q_clean 0, rise_pulse 0, fall_pulse 0, stable 1, glitch_count 0.
REQ-025 Reset asserted mid-confirmation SHALL abort it with no pulse generated.
REQ-026 After reset_n rises with d_async=1, the block SHALL follow the normal path: q_clean=1 and rise_pulse after REQ-019 latency.

Verification
REQ-027 Reset, d_async=0 held 200 ns -> q_clean=0, stable=1, glitch_count=0, no pulses.
REQ-028 10 ns clk, defaults, d_async 0->1 before edge 1 held -> q_clean=1 at edge 6, rise_pulse high exactly at edge 6 only.
REQ-029 d_async high 20 ns (2 cycles) then low -> q_clean stays 0, glitch_count=1, stable back to 1.
REQ-030 From STABLE_HI, 300 repeated 2-cycle low glitches -> q_clean stays 1, glitch_count=255; clear_glitch one cycle -> 0.
REQ-031 d_async=1, reset_n pulsed low during CONFIRM_HI (cnt=2) -> outputs at reset values asynchronously; after release q_clean rises at edge 6 from release.
REQ-032 Full 1->0 transition from STABLE_HI -> fall_pulse single cycle at edge 6, q_clean=0, rise_pulse never asserted.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes a raw asynchronous level, debounces it with a
// four-state confirm FSM, and reports a clean level, edge pulses, a stable flag
// and a saturating count of rejected transitions.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       d_async,
  input  logic       clear_glitch,
  output logic       q_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       stable,
  output logic [7:0] glitch_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_sync;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_clean_q, q_clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             stable_q, stable_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             glitch_inc;

  // Synchronizer shift: d_async enters stage 0 only; the last stage is d_sync.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // Debounce FSM: a new level must be seen DEBOUNCE_CYCLES times in a row.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_clean_d  = q_clean_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (d_sync) begin
          state_d = CONFIRM_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_HI: begin
        if (d_sync) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = STABLE_HI;
            cnt_d     = '0;
            q_clean_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!d_sync) begin
          state_d = CONFIRM_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_LO: begin
        if (!d_sync) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = STABLE_LO;
            cnt_d     = '0;
            q_clean_d = 1'b0;
            fall_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Stable flag is registered from the next state so it lines up with state_q.
  always_comb begin
    stable_d = (state_d == STABLE_LO) || (state_d == STABLE_HI);
  end

  // Glitch counter: clear has priority over a same-cycle rejection; saturates.
  always_comb begin
    glitch_d = glitch_q;
    if (clear_glitch) begin
      glitch_d = 8'd0;
    end else if (glitch_inc && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // All state, async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      q_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stable_q  <= 1'b1;
      glitch_q  <= 8'd0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_clean_q <= q_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stable_q  <= stable_d;
      glitch_q  <= glitch_d;
    end
  end

  assign q_clean      = q_clean_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign stable       = stable_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with default parameters (2 sync, 4 debounce).
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_input_conditioner;

  logic       clk;
  logic       reset_n;
  logic       d_async;
  logic       clear_glitch;
  logic       q_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       stable;
  logic [7:0] glitch_count;

  int total;
  int bad;
  int exp_g;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d_async      (d_async),
    .clear_glitch (clear_glitch),
    .q_clean      (q_clean),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .stable       (stable),
    .glitch_count (glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b1; d_async = 1'b0; clear_glitch = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (q_clean !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 ||
        stable !== 1'b1 || glitch_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_async: q=%b r=%b f=%b s=%b g=%0d want q=0 r=0 f=0 s=1 g=0",
               q_clean, rise_pulse, fall_pulse, stable, glitch_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (q_clean !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 ||
          stable !== 1'b1 || glitch_count !== 8'd0) begin
        bad++;
        $display("FAIL reset_idle e=%0d: q=%b r=%b f=%b s=%b g=%0d want 0 0 0 1 0",
                 e, q_clean, rise_pulse, fall_pulse, stable, glitch_count);
      end
    end
    exp_g = 0;
  endtask

  // Full level change; pol=1 for 0->1, pol=0 for 1->0. Expects change at edge 6.
  task automatic test_edge(input logic pol);
    @(negedge clk);
    d_async = pol;
    for (int e = 1; e <= 8; e++) begin
      logic eq, er, ef, es;
      @(posedge clk); @(negedge clk);
      eq = (e >= 6) ? pol : ~pol;
      er = (e == 6) && pol;
      ef = (e == 6) && !pol;
      es = !(e >= 3 && e <= 5);
      total++;
      if (q_clean !== eq || rise_pulse !== er || fall_pulse !== ef || stable !== es) begin
        bad++;
        $display("FAIL edge_pol%0b e=%0d: q=%b r=%b f=%b s=%b want q=%b r=%b f=%b s=%b",
                 pol, e, q_clean, rise_pulse, fall_pulse, stable, eq, er, ef, es);
      end
    end
  endtask

  // Two-cycle high pulse from STABLE_LO: rejected, counted once.
  task automatic test_glitch();
    @(negedge clk);
    d_async = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      logic es;
      @(posedge clk); @(negedge clk);
      if (e == 2) d_async = 1'b0;
      es = !(e == 3 || e == 4);
      total++;
      if (q_clean !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || stable !== es) begin
        bad++;
        $display("FAIL glitch e=%0d: q=%b r=%b f=%b s=%b want q=0 r=0 f=0 s=%b",
                 e, q_clean, rise_pulse, fall_pulse, stable, es);
      end
    end
    exp_g++;
    total++;
    if (glitch_count !== exp_g[7:0]) begin
      bad++;
      $display("FAIL glitch_count: got %0d want %0d", glitch_count, exp_g);
    end
  endtask

  // Pulse of DEBOUNCE_CYCLES-1 is rejected; pulse of exactly DEBOUNCE_CYCLES is accepted.
  task automatic test_boundary();
    @(negedge clk);
    d_async = 1'b1;
    repeat (3) @(negedge clk);
    d_async = 1'b0;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (q_clean !== 1'b0 || rise_pulse !== 1'b0) begin
        bad++;
        $display("FAIL short_pulse: q=%b r=%b want q=0 r=0", q_clean, rise_pulse);
      end
    end
    exp_g++;
    total++;
    if (glitch_count !== exp_g[7:0]) begin
      bad++;
      $display("FAIL short_pulse_count: got %0d want %0d", glitch_count, exp_g);
    end
    d_async = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 4) d_async = 1'b0;
      if (e == 6) begin
        total++;
        if (q_clean !== 1'b1 || rise_pulse !== 1'b1) begin
          bad++;
          $display("FAIL exact_pulse e=6: q=%b r=%b want q=1 r=1", q_clean, rise_pulse);
        end
      end
    end
    repeat (6) @(negedge clk);
    total++;
    if (q_clean !== 1'b0 || stable !== 1'b1 || glitch_count !== exp_g[7:0]) begin
      bad++;
      $display("FAIL exact_pulse_return: q=%b s=%b g=%0d want q=0 s=1 g=%0d",
               q_clean, stable, glitch_count, exp_g);
    end
  endtask

  // 300 two-cycle low glitches from STABLE_HI; count saturates, then clears.
  task automatic test_saturate();
    @(negedge clk);
    d_async = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (q_clean !== 1'b1) begin
      bad++;
      $display("FAIL sat_setup: q=%b want 1", q_clean);
    end
    for (int i = 0; i < 300; i++) begin
      d_async = 1'b0;
      repeat (2) @(negedge clk);
      d_async = 1'b1;
      repeat (2) begin
        @(negedge clk);
        total++;
        if (q_clean !== 1'b1 || fall_pulse !== 1'b0 || rise_pulse !== 1'b0) begin
          bad++;
          $display("FAIL sat_hold i=%0d: q=%b f=%b r=%b want q=1 f=0 r=0",
                   i, q_clean, fall_pulse, rise_pulse);
        end
      end
    end
    repeat (4) @(negedge clk);
    exp_g = 255;
    total++;
    if (glitch_count !== 8'd255 || stable !== 1'b1) begin
      bad++;
      $display("FAIL sat_count: g=%0d s=%b want g=255 s=1", glitch_count, stable);
    end
    clear_glitch = 1'b1;
    @(negedge clk);
    clear_glitch = 1'b0;
    exp_g = 0;
    total++;
    if (glitch_count !== 8'd0) begin
      bad++;
      $display("FAIL sat_clear: g=%0d want 0", glitch_count);
    end
    d_async = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Clear coinciding with a rejection edge: clear wins.
  task automatic test_clear_wins();
    @(negedge clk);
    d_async = 1'b1;
    repeat (2) @(negedge clk);
    d_async = 1'b0;
    repeat (6) @(negedge clk);
    exp_g = 1;
    total++;
    if (glitch_count !== 8'd1) begin
      bad++;
      $display("FAIL clr_pre: g=%0d want 1", glitch_count);
    end
    d_async = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 2) d_async = 1'b0;
      clear_glitch = (e == 4);
    end
    clear_glitch = 1'b0;
    exp_g = 0;
    total++;
    if (glitch_count !== 8'd0 || q_clean !== 1'b0) begin
      bad++;
      $display("FAIL clr_wins: g=%0d q=%b want g=0 q=0", glitch_count, q_clean);
    end
  endtask

  // Reset pulsed mid-confirmation (cnt=2), then normal rise from release.
  task automatic test_reset_mid();
    @(negedge clk);
    d_async = 1'b1;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (stable !== 1'b0 || q_clean !== 1'b0) begin
      bad++;
      $display("FAIL mid_confirm: s=%b q=%b want s=0 q=0", stable, q_clean);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (q_clean !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 ||
        stable !== 1'b1 || glitch_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset_async: q=%b r=%b f=%b s=%b g=%0d want 0 0 0 1 0",
               q_clean, rise_pulse, fall_pulse, stable, glitch_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      logic eq, er;
      @(posedge clk); @(negedge clk);
      eq = (e >= 6);
      er = (e == 6);
      total++;
      if (q_clean !== eq || rise_pulse !== er || fall_pulse !== 1'b0) begin
        bad++;
        $display("FAIL post_reset e=%0d: q=%b r=%b f=%b want q=%b r=%b f=0",
                 e, q_clean, rise_pulse, fall_pulse, eq, er);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_g = 0;
    test_reset();
    test_edge(1'b1);
    test_edge(1'b0);
    test_glitch();
    test_boundary();
    test_saturate();
    test_clear_wins();
    test_reset_mid();
    test_edge(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
